cus19_dmem_responder: RTL and testbench

//  Data-memory responder (slave end) of the cus19 load/store interface. Accepts one LD/ST request at a time

---
 rtl/cus19_mem_pkg.sv | 19 +
 rtl/cus19_parity_gen.sv | 12 +
 rtl/cus19_dmem_responder.sv | 152 +++++++++++++++
 tb/tb_cus19_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cus19_mem_pkg.sv
// Shared definitions for the cus19 load/store memory path: responder FSM states,
// LD/ST opcode constants and response field widths.
package cus19_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Opcode field of the 19-bit instruction and the bit that selects ST over LD.
    localparam logic [2:0] LDST_OPCODE  = 3'b001;
    localparam int         LDST_SEL_BIT = 15;

    localparam int RSP_DATA_W = 8;
    localparam int RSP_TAG_W  = 4;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/cus19_parity_gen.sv
// Combinational even-parity generator: the output bit makes the total count of ones
// across data and parity even.
module cus19_parity_gen #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] data_i,
    output logic             par_o
);

    assign par_o = ^data_i;

endmodule

// File: rtl/cus19_dmem_responder.sv
// Data-memory responder of the cus19 load/store interface: one request at a time,
// fixed wait, tagged response. Optional byte parity under CUS19_DMEM_PARITY_EN.
module cus19_dmem_responder
    import cus19_mem_pkg::*;
#(
    parameter int Addr_Width     = 11,
    parameter int Data_Width     = RSP_DATA_W,
    parameter int Reg_Addr_Width = RSP_TAG_W,
    parameter int Mem_Depth      = 256,
    parameter int Wait_Cycles    = 1
) (
    input  logic                      cus19_clk_in,
    input  logic                      cus19_rst_in,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [Addr_Width-1:0]     req_addr,
    input  logic [Data_Width-1:0]     req_wdata,
    input  logic [Reg_Addr_Width-1:0] req_rd_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_is_load,
    output logic [Data_Width-1:0]     rsp_rdata,
    output logic [Reg_Addr_Width-1:0] rsp_rd_addr,
    output logic                      rsp_err,
    output logic                      rsp_par_err
);

    localparam int                    IdxW     = $clog2(Mem_Depth);
    localparam logic [Addr_Width:0]   DepthLim = Mem_Depth[Addr_Width:0];
    localparam logic [WAIT_CNT_W-1:0] LastCnt  = (Wait_Cycles > 0) ?
                                                 WAIT_CNT_W'(Wait_Cycles - 1) : '0;

    dmem_state_e               state_q, state_d;
    logic [WAIT_CNT_W-1:0]     cnt_q, cnt_d;
    logic                      rsp_is_load_q, rsp_is_load_d;
    logic                      rsp_err_q, rsp_err_d;
    logic                      rsp_par_err_q, rsp_par_err_d;
    logic [Data_Width-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [Reg_Addr_Width-1:0] rsp_rd_addr_q, rsp_rd_addr_d;

    logic [Data_Width-1:0]     mem_q [Mem_Depth];
    logic [IdxW-1:0]           idx;
    logic [Data_Width-1:0]     rd_byte;
    logic                      in_range;
    logic                      mem_we;
    logic                      par_mismatch;

    assign idx      = req_addr[IdxW-1:0];
    assign rd_byte  = mem_q[idx];
    assign in_range = ({1'b0, req_addr} < DepthLim);
    // Reset gating keeps a request presented during reset from writing memory.
    assign mem_we   = (state_q == IDLE) && req_valid && req_we && in_range && cus19_rst_in;

    always_ff @(posedge cus19_clk_in) begin
        if (mem_we) begin
            mem_q[idx] <= req_wdata;
        end
    end

`ifdef CUS19_DMEM_PARITY_EN
    logic mem_par_q [Mem_Depth];
    logic wr_par;
    logic rd_par;

    cus19_parity_gen #(.Width(Data_Width)) u_par_wr (
        .data_i (req_wdata),
        .par_o  (wr_par)
    );

    cus19_parity_gen #(.Width(Data_Width)) u_par_rd (
        .data_i (rd_byte),
        .par_o  (rd_par)
    );

    always_ff @(posedge cus19_clk_in) begin
        if (mem_we) begin
            mem_par_q[idx] <= wr_par;
        end
    end

    assign par_mismatch = (rd_par != mem_par_q[idx]);
`else
    assign par_mismatch = 1'b0;
`endif

    always_ff @(posedge cus19_clk_in or negedge cus19_rst_in) begin
        if (!cus19_rst_in) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rsp_is_load_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_par_err_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_rd_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rsp_is_load_q <= rsp_is_load_d;
            rsp_err_q     <= rsp_err_d;
            rsp_par_err_q <= rsp_par_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_rd_addr_q <= rsp_rd_addr_d;
        end
    end

    // Payload is captured only on the accept edge, so it stays frozen through WAIT and RESP.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rsp_is_load_d = rsp_is_load_q;
        rsp_err_d     = rsp_err_q;
        rsp_par_err_d = rsp_par_err_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_rd_addr_d = rsp_rd_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d       = (Wait_Cycles > 0) ? WAIT : RESP;
                    cnt_d         = '0;
                    rsp_is_load_d = !req_we;
                    rsp_err_d     = !in_range;
                    rsp_rd_addr_d = req_rd_addr;
                    rsp_rdata_d   = (!req_we && in_range) ? rd_byte : '0;
                    rsp_par_err_d = !req_we && in_range && par_mismatch;
                end
            end
            WAIT: begin
                if (cnt_q == LastCnt) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_is_load = rsp_is_load_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_rd_addr = rsp_rd_addr_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_par_err = rsp_par_err_q;

endmodule

// File: tb/tb_cus19_dmem_responder.sv
// Self-checking bench for cus19_dmem_responder: transaction-level model with a
// per-cycle compare process, directed literal checks and a randomized phase.
module tb_cus19_dmem_responder;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int RW    = 4;
    localparam int DEPTH = 256;
    localparam int WAITC = 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [RW-1:0] req_rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_is_load;
    logic [DW-1:0] rsp_rdata;
    logic [RW-1:0] rsp_rd_addr;
    logic          rsp_err;
    logic          rsp_par_err;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b1;

    cus19_dmem_responder #(
        .Addr_Width(AW), .Data_Width(DW), .Reg_Addr_Width(RW),
        .Mem_Depth(DEPTH), .Wait_Cycles(WAITC)
    ) dut (
        .cus19_clk_in (clk),
        .cus19_rst_in (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd_addr  (req_rd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_is_load  (rsp_is_load),
        .rsp_rdata    (rsp_rdata),
        .rsp_rd_addr  (rsp_rd_addr),
        .rsp_err      (rsp_err),
        .rsp_par_err  (rsp_par_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding request, response visible WAITC edges after accept.
    logic [DW-1:0] memModel [DEPTH];
    bit            busy = 1'b0;
    int            rem  = 0;
    logic          expLoad, expErr;
    logic [DW-1:0] expData;
    logic [RW-1:0] expTag;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
            rem  = 0;
        end else if (busy) begin
            if (rem > 0) rem--;
            else if (rsp_ready) busy = 1'b0;
        end else if (req_valid) begin
            busy    = 1'b1;
            rem     = WAITC;
            expLoad = !req_we;
            expErr  = (int'(req_addr) >= DEPTH);
            expTag  = req_rd_addr;
            expData = '0;
            if (!expErr) begin
                if (req_we) memModel[req_addr] = req_wdata;
                else        expData = memModel[req_addr];
            end
        end
    end

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n && checkEn) begin
            checkOutput("req_ready", 32'(req_ready), 32'(!busy));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(busy && rem == 0));
            if (busy && rem == 0) begin
                checkOutput("rsp_is_load", 32'(rsp_is_load), 32'(expLoad));
                checkOutput("rsp_err",     32'(rsp_err),     32'(expErr));
                checkOutput("rsp_rdata",   32'(rsp_rdata),   32'(expData));
                checkOutput("rsp_rd_addr", 32'(rsp_rd_addr), 32'(expTag));
                checkOutput("rsp_par_err", 32'(rsp_par_err), 32'd0);
            end
        end
    end

    // Presents one request and returns on the negedge right after it is accepted.
    task automatic applyStimulus(input logic we, input int addr, input logic [DW-1:0] wd,
                                 input logic [RW-1:0] tag);
        int guard;
        @(negedge clk);
        req_we      = we;
        req_addr    = AW'(addr);
        req_wdata   = wd;
        req_rd_addr = tag;
        req_valid   = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            mismatched++;
            $display("[TB] FAIL req_accept_timeout: got req_ready=0, expected 1");
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(input int hold);
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            mismatched++;
            $display("[TB] FAIL rsp_timeout: got rsp_valid=0, expected 1");
        end
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset rsp_valid",   32'(rsp_valid),   32'd0);
        checkOutput("reset rsp_is_load", 32'(rsp_is_load), 32'd0);
        checkOutput("reset rsp_rdata",   32'(rsp_rdata),   32'd0);
        checkOutput("reset rsp_rd_addr", 32'(rsp_rd_addr), 32'd0);
        checkOutput("reset rsp_err",     32'(rsp_err),     32'd0);
        checkOutput("reset rsp_par_err", 32'(rsp_par_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("reset req_ready", 32'(req_ready), 32'd1);

        $display("[TB] filling memory");
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b1, a, DW'($urandom), RW'($urandom));
            waitRsp(0);
        end

        // Load latency and payload with literal expectations.
        applyStimulus(1'b1, 2, 8'd5, 4'd0);
        waitRsp(0);
        applyStimulus(1'b0, 2, 8'd0, 4'd2);
        checkOutput("t1 valid one cycle after accept", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1 rsp_valid",   32'(rsp_valid),   32'd1);
        checkOutput("t1 rsp_rdata",   32'(rsp_rdata),   32'd5);
        checkOutput("t1 rsp_rd_addr", 32'(rsp_rd_addr), 32'd2);
        checkOutput("t1 rsp_is_load", 32'(rsp_is_load), 32'd1);
        waitRsp(0);

        // Store ack then load back.
        applyStimulus(1'b1, 4, 8'd10, 4'd3);
        @(negedge clk);
        checkOutput("t2 ack is_load", 32'(rsp_is_load), 32'd0);
        checkOutput("t2 ack rdata",   32'(rsp_rdata),   32'd0);
        waitRsp(0);
        applyStimulus(1'b0, 4, 8'd0, 4'd4);
        @(negedge clk);
        checkOutput("t2 load rdata", 32'(rsp_rdata), 32'd10);
        waitRsp(0);

        // Response held under back-pressure.
        applyStimulus(1'b1, 20, 8'h77, 4'd1);
        waitRsp(0);
        applyStimulus(1'b0, 20, 8'h00, 4'd9);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3 held rsp_valid", 32'(rsp_valid),   32'd1);
            checkOutput("t3 held rsp_rdata", 32'(rsp_rdata),   32'h77);
            checkOutput("t3 held tag",       32'(rsp_rd_addr), 32'd9);
            checkOutput("t3 held req_ready", 32'(req_ready),   32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("t3 back to idle req_ready", 32'(req_ready), 32'd1);
        checkOutput("t3 back to idle rsp_valid", 32'(rsp_valid), 32'd0);

        // Out-of-range accesses; 300 aliases 44 in the low bits.
        applyStimulus(1'b1, 44, 8'h11, 4'd0);
        waitRsp(0);
        applyStimulus(1'b0, 300, 8'h00, 4'd5);
        @(negedge clk);
        checkOutput("t4 ld err",   32'(rsp_err),   32'd1);
        checkOutput("t4 ld rdata", 32'(rsp_rdata), 32'd0);
        waitRsp(0);
        applyStimulus(1'b1, 300, 8'hEE, 4'd6);
        @(negedge clk);
        checkOutput("t4 st err", 32'(rsp_err), 32'd1);
        waitRsp(0);
        applyStimulus(1'b0, 44, 8'h00, 4'd7);
        @(negedge clk);
        checkOutput("t4 alias untouched", 32'(rsp_rdata), 32'h11);
        waitRsp(0);

        // Reset during WAIT after an accepted store.
        applyStimulus(1'b1, 7, 8'h3C, 4'd8);
        rst_n = 1'b0;
        #1 checkOutput("t5 rsp_valid in reset", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 7, 8'h00, 4'd8);
        @(negedge clk);
        checkOutput("t5 store survived reset", 32'(rsp_rdata), 32'h3C);
        waitRsp(0);

`ifdef CUS19_DMEM_PARITY_EN
        applyStimulus(1'b1, 9, 8'hA5, 4'd1);
        waitRsp(0);
        checkEn = 1'b0;
        dut.mem_q[9][0] = ~dut.mem_q[9][0];
        applyStimulus(1'b0, 9, 8'h00, 4'd1);
        @(negedge clk);
        checkOutput("t6 rdata",   32'(rsp_rdata),   32'hA4);
        checkOutput("t6 par_err", 32'(rsp_par_err), 32'd1);
        waitRsp(0);
        memModel[9] = 8'hA4;
        applyStimulus(1'b1, 9, 8'hA4, 4'd1);
        waitRsp(0);
        checkEn = 1'b1;
`endif

        // Randomized traffic: requests may wait across RESP, consumer back-pressures randomly.
        $display("[TB] random phase");
        begin
            bit pend;
            bit readyPrev;
            pend = 1'b0;
            readyPrev = 1'b0;
            repeat (1500) begin
                @(negedge clk);
                if (pend && readyPrev) pend = 1'b0;
                if (!pend && $urandom_range(0, 2) != 0) begin
                    pend        = 1'b1;
                    req_we      = 1'($urandom_range(0, 1));
                    req_addr    = AW'($urandom_range(0, 319));
                    req_wdata   = DW'($urandom);
                    req_rd_addr = RW'($urandom);
                end
                req_valid = pend;
                rsp_ready = 1'($urandom_range(0, 1));
                readyPrev = req_ready;
            end
            @(negedge clk);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            repeat (10) @(negedge clk);
            rsp_ready = 1'b0;
            checkOutput("drain req_ready", 32'(req_ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
